// File: rtl/rom_prefetch_pkg.sv
// Shared types for the ROM prefetch buffer: FSM states, cache-entry layout and default address width.
package rom_prefetch_pkg;

    localparam int ROM_AW    = 23;
    // Tags are stored zero-extended so one entry layout serves every AW up to 32.
    localparam int ROM_TAG_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        DEMAND,
        PREF,
        PREF_WAIT
    } state_t;

    typedef struct packed {
        logic [ROM_TAG_W-1:0] tag;
        logic [15:0]          data;
        logic                 valid;
    } entry_t;

endpackage

// File: rtl/rom_prefetch_buffer_if.sv
// Toggle-handshake word read bus: master owns req/a, slave answers with ack/q.
interface rom_prefetch_buffer_if import rom_prefetch_pkg::*; #(
    parameter int AW = ROM_AW
);
    logic          req;
    logic          ack;
    logic [AW-1:0] a;
    logic [15:0]   q;

    modport master (output req, output a, input ack, input q);
    modport slave  (input req, input a, output ack, output q);
endinterface

// File: rtl/rom_prefetch_entry.sv
// One cached ROM word: loadable tag/data with a valid bit, clear, and combinational tag match.
module rom_prefetch_entry import rom_prefetch_pkg::*; #(
    parameter int AW = ROM_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          clear,
    input  logic [AW-1:0] load_tag,
    input  logic [15:0]   load_data,
    input  logic [AW-1:0] lookup_a,
    output logic          hit,
    output logic [15:0]   data
);

    entry_t entry_reg;

    // Clear beats load so an invalidate can never be overtaken by a late fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_reg <= '0;
        end else if (clear) begin
            entry_reg.valid <= 1'b0;
        end else if (load) begin
            entry_reg.tag   <= ROM_TAG_W'(load_tag);
            entry_reg.data  <= load_data;
            entry_reg.valid <= 1'b1;
        end
    end

    assign hit  = entry_reg.valid && (entry_reg.tag == ROM_TAG_W'(lookup_a));
    assign data = entry_reg.data;

endmodule

// File: rtl/rom_prefetch_buffer.sv
// ROM read front-end caching the last demand word; with ROM_PREFETCH_EN defined it also
// prefetches the next sequential word into a second entry.
module rom_prefetch_buffer import rom_prefetch_pkg::*; #(
    parameter int AW = ROM_AW
) (
    input  logic                  clk,
    input  logic                  reset,
    rom_prefetch_buffer_if.slave  cpu,
    rom_prefetch_buffer_if.master sd,
    input  logic                  inv
);

`ifdef ROM_PREFETCH_EN
    localparam int N_ENT = 2;
`else
    localparam int N_ENT = 1;
`endif

    state_t        state_reg, state_next;
    logic          cpu_ack_reg, cpu_ack_next;
    logic [15:0]   cpu_q_reg, cpu_q_next;
    logic          sd_req_reg, sd_req_next;
    logic [AW-1:0] sd_a_reg, sd_a_next;
    logic          drop_reg, drop_next;

    logic [N_ENT-1:0] ent_hit;
    logic [N_ENT-1:0] ent_load;
    logic [AW-1:0]    ent_tag   [N_ENT];
    logic [15:0]      ent_wdata [N_ENT];
    logic [15:0]      ent_data  [N_ENT];

    // Entry 0 is CUR (last demand word), entry 1 is NXT (prefetched word).
    for (genvar gi = 0; gi < N_ENT; gi++) begin : g_ent
        rom_prefetch_entry #(.AW(AW)) u_entry (
            .clk       (clk),
            .reset     (reset),
            .load      (ent_load[gi]),
            .clear     (inv),
            .load_tag  (ent_tag[gi]),
            .load_data (ent_wdata[gi]),
            .lookup_a  (cpu.a),
            .hit       (ent_hit[gi]),
            .data      (ent_data[gi])
        );
    end

    logic pending, done, result_ok, hit_cur;
    assign pending   = cpu.req != cpu_ack_reg;
    assign done      = sd.ack == sd_req_reg;
    // A result is cacheable only if no invalidate arrived since it was issued.
    assign result_ok = !drop_reg && !inv;
    assign hit_cur   = ent_hit[0] && !inv;

`ifdef ROM_PREFETCH_EN
    logic          hit_nxt;
    logic [AW-1:0] a_inc;
    assign hit_nxt = ent_hit[1] && !inv;
    assign a_inc   = cpu.a + AW'(1);
`endif

    always_comb begin
        state_next   = state_reg;
        cpu_ack_next = cpu_ack_reg;
        cpu_q_next   = cpu_q_reg;
        sd_req_next  = sd_req_reg;
        sd_a_next    = sd_a_reg;
        drop_next    = drop_reg || inv;
        ent_load     = '0;
        ent_tag[0]   = cpu.a;
        ent_wdata[0] = sd.q;
`ifdef ROM_PREFETCH_EN
        ent_tag[1]   = sd_a_reg;
        ent_wdata[1] = sd.q;
`endif
        case (state_reg)
            IDLE: begin
                if (pending) begin
                    if (hit_cur) begin
                        cpu_ack_next = cpu.req;
                        cpu_q_next   = ent_data[0];
`ifdef ROM_PREFETCH_EN
                    end else if (hit_nxt) begin
                        cpu_ack_next = cpu.req;
                        cpu_q_next   = ent_data[1];
                        ent_load[0]  = 1'b1;
                        ent_wdata[0] = ent_data[1];
                        sd_req_next  = ~sd_req_reg;
                        sd_a_next    = a_inc;
                        drop_next    = 1'b0;
                        state_next   = PREF;
`endif
                    end else begin
                        sd_req_next = ~sd_req_reg;
                        sd_a_next   = cpu.a;
                        drop_next   = 1'b0;
                        state_next  = DEMAND;
                    end
                end
            end
            DEMAND: begin
                if (done) begin
                    cpu_ack_next = cpu.req;
                    cpu_q_next   = sd.q;
                    state_next   = IDLE;
                    if (result_ok) begin
                        ent_load[0] = 1'b1;
`ifdef ROM_PREFETCH_EN
                        sd_req_next = ~sd_req_reg;
                        sd_a_next   = a_inc;
                        drop_next   = 1'b0;
                        state_next  = PREF;
`endif
                    end
                end
            end
`ifdef ROM_PREFETCH_EN
            PREF: begin
                if (done) begin
                    ent_load[1] = result_ok;
                    state_next  = IDLE;
                end else if (pending) begin
                    if (hit_cur) begin
                        cpu_ack_next = cpu.req;
                        cpu_q_next   = ent_data[0];
                    end else begin
                        state_next = PREF_WAIT;
                    end
                end
            end
            PREF_WAIT: begin
                if (done) begin
                    ent_load[1] = result_ok;
                    // The waiting CPU may want exactly the word that just arrived.
                    if (result_ok && (cpu.a == sd_a_reg)) begin
                        cpu_ack_next = cpu.req;
                        cpu_q_next   = sd.q;
                        ent_load[0]  = 1'b1;
                        sd_req_next  = ~sd_req_reg;
                        sd_a_next    = a_inc;
                        drop_next    = 1'b0;
                        state_next   = PREF;
                    end else begin
                        sd_req_next = ~sd_req_reg;
                        sd_a_next   = cpu.a;
                        drop_next   = 1'b0;
                        state_next  = DEMAND;
                    end
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cpu_ack_reg <= 1'b0;
            cpu_q_reg   <= 16'h0000;
            sd_req_reg  <= 1'b0;
            sd_a_reg    <= '0;
            drop_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cpu_ack_reg <= cpu_ack_next;
            cpu_q_reg   <= cpu_q_next;
            sd_req_reg  <= sd_req_next;
            sd_a_reg    <= sd_a_next;
            drop_reg    <= drop_next;
        end
    end

    assign cpu.ack = cpu_ack_reg;
    assign cpu.q   = cpu_q_reg;
    assign sd.req  = sd_req_reg;
    assign sd.a    = sd_a_reg;

endmodule
